// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state types shared by the AXI4-Lite register file
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes
// Ports: aclk/aresetn clock and async active-low reset; aw*/w*/b* write channels;
//        ar*/r* read channels; regs_o flattened contents (register i at [32i+31:32i])
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   regs_o
);
  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic                      live_q;
  w_state_e                  w_state_q, w_state_d;
  logic                      aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [29:0]               aw_idx_q, aw_idx_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [1:0]                bresp_q, bresp_d;
  r_state_e                  r_state_q, r_state_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      aw_hs, w_hs, ar_hs, commit, aw_in_range;
  logic                      unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  // live_q keeps every ready low during reset and raises them on the first edge after release
  assign awready     = live_q && w_state_q == W_IDLE && !aw_full_q;
  assign wready      = live_q && w_state_q == W_IDLE && !w_full_q;
  assign arready     = live_q && r_state_q == R_IDLE;
  assign bvalid      = w_state_q == W_RESP;
  assign rvalid      = r_state_q == R_DATA;
  assign bresp       = bresp_q;
  assign rresp       = rresp_q;
  assign rdata       = rdata_q;
  assign regs_o      = regs_q;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign ar_hs       = arvalid && arready;
  assign commit      = w_state_q == W_IDLE && aw_full_q && w_full_q;
  assign aw_in_range = aw_idx_q < 30'(NUM_REGS);
  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[31:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (commit) begin
      w_state_d = W_RESP;
      bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end
    if (w_state_q == W_RESP && bready) begin
      w_state_d = W_IDLE;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (commit && aw_in_range && aw_idx_q == 30'(i))
        for (int b = 0; b < 4; b++)
          if (wstrb_q[b]) regs_d[i][8*b+:8] = wdata_q[8*b+:8];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
    end
  end
  // Reads sample regs_q, so a same-edge commit to the same register returns the old value
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      r_state_d = R_DATA;
      rdata_d   = '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (araddr[31:2] == 30'(i)) rdata_d = regs_q[i];
      rresp_d = araddr[31:2] < 30'(NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
    end
    if (r_state_q == R_DATA && rready) r_state_d = R_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: scoreboard bench for the AXI4-Lite register file
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;
  localparam int NUM_REGS = 16;
  localparam int W = NUM_REGS * 32;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [W-1:0] regs_o;
  int checks = 0, errors = 0;
  logic [31:0] mdl [NUM_REGS];
  logic [1:0] exp_b_q [$];
  r_exp_t exp_r_q [$];
  logic [W-1:0] snap;
  axi_lite_regfile #(.NUM_REGS(NUM_REGS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] mdl_flat();
    logic [W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[32*i+:32] = mdl[i];
    return f;
  endfunction
  task automatic mdl_clear();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
  endtask
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[31:2]);
    if (a[31:2] < NUM_REGS) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b+:8] = d[8*b+:8];
      exp_b_q.push_back(RESP_OKAY);
    end else exp_b_q.push_back(RESP_SLVERR);
  endtask
  task automatic expect_read(input logic [31:0] a);
    r_exp_t e;
    if (a[31:2] < NUM_REGS) begin
      e.data = mdl[int'(a[31:2])];
      e.resp = RESP_OKAY;
    end else begin
      e.data = '0;
      e.resp = RESP_SLVERR;
    end
    exp_r_q.push_back(e);
  endtask
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) check("aw_timeout", 0, 1);
    @(negedge aclk); awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge aclk); n++; end
    if (!wready) check("w_timeout", 0, 1);
    @(negedge aclk); wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) check("ar_timeout", 0, 1);
    @(negedge aclk); arvalid = 1'b0;
  endtask
  task automatic collect_b(input string tag);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) check({tag, "_b_timeout"}, 0, 1);
    else if (exp_b_q.size() == 0) check({tag, "_b_unexpected"}, 1, 0);
    else check({tag, "_bresp"}, W'(bresp), W'(exp_b_q.pop_front()));
    @(negedge aclk); bready = 1'b0;
  endtask
  task automatic collect_r(input string tag);
    int n = 0;
    r_exp_t e;
    rready = 1'b1;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    if (!rvalid) check({tag, "_r_timeout"}, 0, 1);
    else if (exp_r_q.size() == 0) check({tag, "_r_unexpected"}, 1, 0);
    else begin
      e = exp_r_q.pop_front();
      check({tag, "_rdata"}, W'(rdata), W'(e.data));
      check({tag, "_rresp"}, W'(rresp), W'(e.resp));
    end
    @(negedge aclk); rready = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, W'(awready), 0);
    check({tag, "_wready"}, W'(wready), 0);
    check({tag, "_arready"}, W'(arready), 0);
    check({tag, "_bvalid"}, W'(bvalid), 0);
    check({tag, "_rvalid"}, W'(rvalid), 0);
    check({tag, "_bresp"}, W'(bresp), 0);
    check({tag, "_rresp"}, W'(rresp), 0);
    check({tag, "_rdata"}, W'(rdata), 0);
    check({tag, "_regs"}, regs_o, 0);
  endtask
  task automatic release_reset(input string tag);
    @(negedge aclk); aresetn = 1'b1;
    #1;
    check({tag, "_arready_pre"}, W'(arready), 0);
    @(negedge aclk);
    check({tag, "_awready_post"}, W'(awready), 1);
    check({tag, "_wready_post"}, W'(wready), 1);
    check({tag, "_arready_post"}, W'(arready), 1);
  endtask
  initial begin
    mdl_clear();
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    release_reset("reset");
    // AW and W in the same cycle
    expect_write(32'h04, 32'hDEADBEEF, 4'hF);
    fork
      send_aw(32'h04);
      send_w(32'hDEADBEEF, 4'hF);
    join
    check("t1_bvalid_early", W'(bvalid), 0);
    @(negedge aclk);
    check("t1_bvalid", W'(bvalid), 1);
    collect_b("t1");
    check("t1_regs", regs_o, mdl_flat());
    expect_read(32'h04);
    send_ar(32'h04);
    collect_r("t1");
    // W three cycles ahead of AW, partial strobes
    expect_write(32'h08, 32'hAABBCCDD, 4'hF);
    fork
      send_aw(32'h08);
      send_w(32'hAABBCCDD, 4'hF);
    join
    collect_b("t2a");
    expect_write(32'h08, 32'h11223344, 4'b0101);
    send_w(32'h11223344, 4'b0101);
    check("t2_wready_held", W'(wready), 0);
    check("t2_awready_open", W'(awready), 1);
    repeat (2) @(negedge aclk);
    send_aw(32'h08);
    collect_b("t2b");
    check("t2_reg", W'(regs_o[95:64]), W'(32'hAA22CC44));
    expect_read(32'h08);
    send_ar(32'h08);
    collect_r("t2");
    // out of range
    snap = mdl_flat();
    expect_write(32'h40, 32'h12345678, 4'hF);
    fork
      send_aw(32'h40);
      send_w(32'h12345678, 4'hF);
    join
    collect_b("t3");
    check("t3_regs_unchanged", regs_o, snap);
    expect_read(32'h40);
    send_ar(32'h40);
    collect_r("t3");
    // bready held low
    expect_write(32'h10, 32'hCAFEF00D, 4'hF);
    fork
      send_aw(32'h10);
      send_w(32'hCAFEF00D, 4'hF);
    join
    @(negedge aclk);
    for (int i = 0; i < 5; i++) begin
      check("t4_bvalid", W'(bvalid), 1);
      check("t4_bresp", W'(bresp), 0);
      check("t4_awready", W'(awready), 0);
      check("t4_wready", W'(wready), 0);
      @(negedge aclk);
    end
    collect_b("t4");
    check("t4_regs", regs_o, mdl_flat());
    // read and commit on the same edge
    expect_write(32'h0C, 32'h1, 4'hF);
    fork
      send_aw(32'h0C);
      send_w(32'h1, 4'hF);
    join
    collect_b("t5a");
    expect_read(32'h0C);
    expect_write(32'h0C, 32'h2, 4'hF);
    fork
      send_aw(32'h0C);
      send_w(32'h2, 4'hF);
    join
    send_ar(32'h0C);
    collect_r("t5_old");
    collect_b("t5b");
    expect_read(32'h0C);
    send_ar(32'h0C);
    collect_r("t5_new");
    // reset while a read is pending and a write is half accepted
    send_ar(32'h04);
    check("t6_rvalid", W'(rvalid), 1);
    send_aw(32'h14);
    check("t6_awready_held", W'(awready), 0);
    aresetn = 1'b0;
    #1;
    check_all_zero("t6");
    mdl_clear();
    release_reset("t6");
    expect_write(32'h14, 32'h55AA55AA, 4'hF);
    fork
      send_aw(32'h14);
      send_w(32'h55AA55AA, 4'hF);
    join
    collect_b("t6");
    check("t6_regs", regs_o, mdl_flat());
    expect_read(32'h04);
    send_ar(32'h04);
    collect_r("t6_cleared");
    expect_read(32'h14);
    send_ar(32'h14);
    collect_r("t6_new");
    check("sb_empty", W'(exp_b_q.size() + exp_r_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
